// File: rtl/fft_stream_feeder.sv
// Streams FFT_LENGTH-sample packets from a 1-cycle-latency sample memory into an Avalon-ST FFT sink.
// A 2-entry FIFO absorbs sink backpressure; frames are only started or stopped on packet boundaries.
module fft_stream_feeder #(
  parameter int FFT_LENGTH  = 256,
  parameter int DATA_W      = 16,
  parameter int SINK_W      = 18,
  parameter int ADDR_W      = 16,
  parameter int WAIT_CYCLES = 1048575,
  parameter int NUM_FRAMES  = 0,
  parameter int SIGNED_IN   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_enable,
  output logic              o_rd_req,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic [SINK_W-1:0] sink_real,
  output logic [SINK_W-1:0] sink_imag,
  output logic              sink_valid,
  output logic              sink_startofpacket,
  output logic              sink_endofpacket,
  input  logic              sink_ready,
  output logic [15:0]       o_frame_cnt,
  output logic              o_busy,
  output logic              o_done
);

  localparam int IDX_W = $clog2(FFT_LENGTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT_LENGTH - 1);
  localparam logic [31:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 32'(WAIT_CYCLES - 1) : 32'd0;

  typedef enum logic [1:0] {S_WAIT, S_RUN, S_IDLE, S_DONE} state_t;

  state_t            state, state_next;
  logic [31:0]       wait_cnt;
  logic [IDX_W-1:0]  index;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       frame_cnt, frame_cnt_inc;
  logic              frame_issued;
  logic              pend, pend_sop, pend_eop;
  logic [DATA_W+1:0] fifo_mem [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        count;
  logic [DATA_W-1:0] head_data;
  logic              head_sop, head_eop;
  logic              xfer, eop_xfer, wait_done, issue_ok;

  assign {head_sop, head_eop, head_data} = fifo_mem[rd_ptr];
  assign sink_valid    = (count != 2'd0);
  assign xfer          = sink_valid & sink_ready;
  assign eop_xfer      = xfer & head_eop;
  assign wait_done     = (wait_cnt == WAIT_LAST);
  assign frame_cnt_inc = (frame_cnt == 16'hFFFF) ? frame_cnt : frame_cnt + 16'd1;

  // A slot freed by this cycle's transfer counts as space, so one read can be in flight every cycle.
  assign issue_ok = ({1'b0, count} + {2'b00, pend}) < (3'd2 + {2'b00, xfer});
  assign o_rd_req = (state == S_RUN) && !frame_issued && issue_ok;

  assign o_rd_addr          = addr;
  assign o_frame_cnt        = frame_cnt;
  assign o_busy             = (state == S_RUN);
  assign o_done             = (state == S_DONE);
  assign sink_imag          = '0;
  assign sink_startofpacket = sink_valid & head_sop;
  assign sink_endofpacket   = sink_valid & head_eop;

  always_comb begin
    sink_real = '0;
    if (sink_valid) begin
      if (SIGNED_IN != 0) sink_real = SINK_W'($signed(head_data));
      else                sink_real = SINK_W'(head_data);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_WAIT: if (wait_done && i_enable) state_next = S_RUN;
      S_RUN: begin
        if (eop_xfer) begin
          if ((NUM_FRAMES != 0) && ({16'd0, frame_cnt_inc} == 32'(NUM_FRAMES)))
            state_next = S_DONE;
          else if (!i_enable)
            state_next = S_IDLE;
        end
      end
      S_IDLE: if (i_enable) state_next = S_RUN;
      default: state_next = S_DONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_WAIT;
      wait_cnt     <= '0;
      index        <= '0;
      addr         <= '0;
      frame_cnt    <= '0;
      frame_issued <= 1'b0;
      pend         <= 1'b0;
      pend_sop     <= 1'b0;
      pend_eop     <= 1'b0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      count        <= '0;
    end else begin
      state <= state_next;
      if (state == S_WAIT && !wait_done) wait_cnt <= wait_cnt + 32'd1;
      pend <= o_rd_req;
      if (o_rd_req) begin
        pend_sop <= (index == '0);
        pend_eop <= (index == LAST_IDX);
        index    <= index + 1'b1;
        addr     <= addr + 1'b1;
        if (index == LAST_IDX) frame_issued <= 1'b1;
      end
      // Issue of the next frame stays blocked until its predecessor's EOP has left the buffer.
      if (eop_xfer) begin
        frame_issued <= 1'b0;
        frame_cnt    <= frame_cnt_inc;
      end
      if (pend) wr_ptr <= ~wr_ptr;
      if (xfer) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, pend} - {1'b0, xfer};
    end
  end

  always_ff @(posedge clk) begin
    if (pend) fifo_mem[wr_ptr] <= {pend_sop, pend_eop, i_rd_data};
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(pend && (count == 2'd2)));

endmodule

// File: tb/tb_fft_stream_feeder.sv
// Self-checking bench: two feeder instances (wrapping 4-bit address / unlimited frames, and
// signed 3-frame run) checked against an address-sequence reference model under random backpressure.
module tb_fft_stream_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic        rst_a = 1'b0, en_a = 1'b0, ready_a = 1'b0;
  logic        req_a, valid_a, sop_a, eop_a, busy_a, done_a;
  logic [3:0]  addr_a;
  logic [15:0] data_a, mask_a = 16'h0000, fcnt_a;
  logic [17:0] real_a, imag_a;

  logic        rst_b = 1'b0, en_b = 1'b0, ready_b = 1'b0;
  logic        req_b, valid_b, sop_b, eop_b, busy_b, done_b;
  logic [15:0] addr_b, data_b, mask_b = 16'h0000, fcnt_b;
  logic [17:0] real_b, imag_b;

  fft_stream_feeder #(.FFT_LENGTH(8), .DATA_W(16), .SINK_W(18), .ADDR_W(4),
                      .WAIT_CYCLES(16), .NUM_FRAMES(0), .SIGNED_IN(0)) dut_a (
    .clk(clk), .rst_n(rst_a), .i_enable(en_a), .o_rd_req(req_a), .o_rd_addr(addr_a),
    .i_rd_data(data_a), .sink_real(real_a), .sink_imag(imag_a), .sink_valid(valid_a),
    .sink_startofpacket(sop_a), .sink_endofpacket(eop_a), .sink_ready(ready_a),
    .o_frame_cnt(fcnt_a), .o_busy(busy_a), .o_done(done_a));

  fft_stream_feeder #(.FFT_LENGTH(16), .DATA_W(16), .SINK_W(18), .ADDR_W(16),
                      .WAIT_CYCLES(4), .NUM_FRAMES(3), .SIGNED_IN(1)) dut_b (
    .clk(clk), .rst_n(rst_b), .i_enable(en_b), .o_rd_req(req_b), .o_rd_addr(addr_b),
    .i_rd_data(data_b), .sink_real(real_b), .sink_imag(imag_b), .sink_valid(valid_b),
    .sink_startofpacket(sop_b), .sink_endofpacket(eop_b), .sink_ready(ready_b),
    .o_frame_cnt(fcnt_b), .o_busy(busy_b), .o_done(done_b));

  // Sample memories: data = address ^ mask, only valid the cycle after a request.
  always @(posedge clk) data_a <= req_a ? ({12'd0, addr_a} ^ mask_a) : 16'hDEAD;
  always @(posedge clk) data_b <= req_b ? (addr_b ^ mask_b) : 16'hDEAD;

  int nxt_a, iss_a, idx_a, frames_a, xfers_a;
  int nxt_b, iss_b, idx_b, frames_b, xfers_b;
  logic held_b;
  logic [17:0] held_real_b;

  task automatic reset_a();
    rst_a = 1'b0;
    @(negedge clk);
    rst_a = 1'b1;
    nxt_a = 0; iss_a = 0; idx_a = 0; frames_a = 0; xfers_a = 0;
  endtask

  task automatic reset_b();
    rst_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    nxt_b = 0; iss_b = 0; idx_b = 0; frames_b = 0; xfers_b = 0; held_b = 1'b0;
  endtask

  task automatic cycle_a(input int pct);
    logic [15:0] d;
    ready_a = ($urandom_range(99) < pct);
    #1;
    checks++;
    if (fcnt_a !== 16'(frames_a)) begin
      failures++; $display("[TB] FAIL frame_cnt_a got %0d want %0d", fcnt_a, frames_a);
    end
    if (req_a === 1'b1) begin
      checks++;
      if (addr_a !== 4'(iss_a)) begin
        failures++; $display("[TB] FAIL rd_addr_a got %0d want %0d", addr_a, iss_a);
      end
      iss_a = (iss_a + 1) % 16;
    end
    if (valid_a === 1'b1 && ready_a) begin
      d = 16'(nxt_a) ^ mask_a;
      checks++;
      if (real_a !== {2'b00, d} || imag_a !== 18'd0 || sop_a !== (idx_a == 0) || eop_a !== (idx_a == 7)) begin
        failures++;
        $display("[TB] FAIL stream_a got real=%h imag=%h sop=%b eop=%b want real=%h imag=0 sop=%b eop=%b",
                 real_a, imag_a, sop_a, eop_a, {2'b00, d}, idx_a == 0, idx_a == 7);
      end
      nxt_a = (nxt_a + 1) % 16;
      xfers_a++;
      if (idx_a == 7) begin idx_a = 0; frames_a++; end else idx_a++;
    end
    @(negedge clk);
  endtask

  task automatic cycle_b(input int pct);
    logic [15:0] d;
    ready_b = ($urandom_range(99) < pct);
    #1;
    checks++;
    if (fcnt_b !== 16'(frames_b)) begin
      failures++; $display("[TB] FAIL frame_cnt_b got %0d want %0d", fcnt_b, frames_b);
    end
    if (held_b) begin
      checks++;
      if (valid_b !== 1'b1 || real_b !== held_real_b) begin
        failures++; $display("[TB] FAIL stall_hold_b got valid=%b real=%h want valid=1 real=%h", valid_b, real_b, held_real_b);
      end
    end
    if (done_b === 1'b1) begin
      checks++;
      if (req_b !== 1'b0 || valid_b !== 1'b0) begin
        failures++; $display("[TB] FAIL done_quiet_b got req=%b valid=%b want 0 0", req_b, valid_b);
      end
    end
    if (req_b === 1'b1) begin
      checks++;
      if (addr_b !== 16'(iss_b)) begin
        failures++; $display("[TB] FAIL rd_addr_b got %0d want %0d", addr_b, iss_b);
      end
      iss_b = (iss_b + 1) % 65536;
    end
    held_b = (valid_b === 1'b1) && !ready_b;
    held_real_b = real_b;
    if (valid_b === 1'b1 && ready_b) begin
      d = 16'(nxt_b) ^ mask_b;
      checks++;
      if (real_b !== {{2{d[15]}}, d} || imag_b !== 18'd0 || sop_b !== (idx_b == 0) || eop_b !== (idx_b == 15)) begin
        failures++;
        $display("[TB] FAIL stream_b got real=%h imag=%h sop=%b eop=%b want real=%h imag=0 sop=%b eop=%b",
                 real_b, imag_b, sop_b, eop_b, {{2{d[15]}}, d}, idx_b == 0, idx_b == 15);
      end
      nxt_b = (nxt_b + 1) % 65536;
      xfers_b++;
      if (idx_b == 15) begin idx_b = 0; frames_b++; end else idx_b++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    en_a = 1'b0; en_b = 1'b0;
    reset_a();
    reset_b();
    checks++;
    if ({req_a, addr_a, real_a, imag_a, valid_a, sop_a, eop_a, fcnt_a, busy_a, done_a} !== '0) begin
      failures++; $display("[TB] FAIL reset_outputs_a got req=%b addr=%h real=%h valid=%b fcnt=%0d busy=%b done=%b want all 0",
                           req_a, addr_a, real_a, valid_a, fcnt_a, busy_a, done_a);
    end
    checks++;
    if ({req_b, addr_b, real_b, imag_b, valid_b, sop_b, eop_b, fcnt_b, busy_b, done_b} !== '0) begin
      failures++; $display("[TB] FAIL reset_outputs_b got req=%b addr=%h real=%h valid=%b fcnt=%0d busy=%b done=%b want all 0",
                           req_b, addr_b, real_b, valid_b, fcnt_b, busy_b, done_b);
    end
    repeat (30) cycle_a(100);
    checks++;
    if (busy_a !== 1'b0 || valid_a !== 1'b0) begin
      failures++; $display("[TB] FAIL wait_hold_a got busy=%b valid=%b want 0 0", busy_a, valid_a);
    end
    en_a = 1'b1;
    cycle_a(100);
    checks++;
    if (busy_a !== 1'b1) begin
      failures++; $display("[TB] FAIL wait_release_a got busy=%b want 1", busy_a);
    end
  endtask

  task automatic test_first_frame();
    mask_a = 16'h0000;
    en_a = 1'b1;
    reset_a();
    for (int c = 0; c < 56; c++) begin
      if (c == 15 || c == 16) begin
        checks++;
        if (busy_a !== (c == 16)) begin
          failures++; $display("[TB] FAIL run_entry cycle=%0d got busy=%b want %b", c, busy_a, c == 16);
        end
      end
      if (c == 17 || c == 18 || (c >= 18 && c <= 25) || (c >= 28 && c <= 35)) begin
        checks++;
        if (valid_a !== (c != 17)) begin
          failures++; $display("[TB] FAIL first_valid_timing cycle=%0d got valid=%b want %b", c, valid_a, c != 17);
        end
      end
      cycle_a(100);
    end
    checks++;
    if (fcnt_a !== 16'd4 || xfers_a != 32) begin
      failures++; $display("[TB] FAIL frames_after_56 got fcnt=%0d xfers=%0d want 4 32", fcnt_a, xfers_a);
    end
  endtask

  task automatic test_enable_drop();
    int guard;
    mask_a = 16'h8000;
    en_a = 1'b1;
    reset_a();
    guard = 0;
    while (frames_a < 1 && guard < 400) begin
      if (valid_a === 1'b1 && frames_a == 0 && idx_a == 1) begin
        checks++;
        if (real_a !== 18'h08001) begin
          failures++; $display("[TB] FAIL unsigned_ext got %h want 08001", real_a);
        end
      end
      if (idx_a >= 3) en_a = 1'b0;
      cycle_a(50);
      guard++;
    end
    checks++;
    if (frames_a != 1 || xfers_a != 8) begin
      failures++; $display("[TB] FAIL drop_frame_complete got frames=%0d xfers=%0d want 1 8", frames_a, xfers_a);
    end
    repeat (6) begin
      cycle_a(50);
      checks++;
      if (valid_a !== 1'b0 || busy_a !== 1'b0 || req_a !== 1'b0 || done_a !== 1'b0) begin
        failures++; $display("[TB] FAIL idle_quiet got valid=%b busy=%b req=%b done=%b want 0 0 0 0", valid_a, busy_a, req_a, done_a);
      end
    end
    en_a = 1'b1;
    guard = 0;
    while (frames_a < 2 && guard < 400) begin
      cycle_a(50);
      guard++;
    end
    checks++;
    if (frames_a != 2 || xfers_a != 16) begin
      failures++; $display("[TB] FAIL resume_frame got frames=%0d xfers=%0d want 2 16", frames_a, xfers_a);
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    en_a = 1'b1;
    guard = 0;
    while (!(valid_a === 1'b1 && idx_a == 5) && guard < 200) begin
      cycle_a(100);
      guard++;
    end
    checks++;
    if (valid_a !== 1'b1 || idx_a != 5) begin
      failures++; $display("[TB] FAIL reach_sample5 got valid=%b idx=%0d want 1 5", valid_a, idx_a);
    end
    cycle_a(0);
    ready_a = 1'b0;
    reset_a();
    checks++;
    if ({req_a, addr_a, real_a, imag_a, valid_a, sop_a, eop_a, fcnt_a, busy_a, done_a} !== '0) begin
      failures++; $display("[TB] FAIL midreset_outputs got req=%b addr=%h real=%h valid=%b fcnt=%0d busy=%b want all 0",
                           req_a, addr_a, real_a, valid_a, fcnt_a, busy_a);
    end
    for (int c = 0; c < 30; c++) begin
      if (c == 5) begin
        checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || valid_a !== 1'b0) begin
          failures++; $display("[TB] FAIL midreset_wait got busy=%b done=%b valid=%b want 0 0 0", busy_a, done_a, valid_a);
        end
      end
      cycle_a(100);
    end
    checks++;
    if (xfers_a != 10) begin
      failures++; $display("[TB] FAIL midreset_restart got xfers=%0d want 10", xfers_a);
    end
  endtask

  task automatic test_backpressure_frames();
    int guard;
    for (int pass = 0; pass < 2; pass++) begin
      mask_b = (pass == 0) ? 16'h8000 : 16'($urandom);
      en_b = 1'b1;
      reset_b();
      guard = 0;
      while (done_b !== 1'b1 && guard < 2000) begin
        if (pass == 0 && valid_b === 1'b1 && frames_b == 0 && idx_b == 1) begin
          checks++;
          if (real_b !== 18'h38001) begin
            failures++; $display("[TB] FAIL signed_ext got %h want 38001", real_b);
          end
        end
        cycle_b(50);
        guard++;
      end
      repeat (10) cycle_b(50);
      checks++;
      if (xfers_b != 48 || done_b !== 1'b1 || fcnt_b !== 16'd3 || busy_b !== 1'b0) begin
        failures++; $display("[TB] FAIL num_frames pass=%0d got xfers=%0d done=%b fcnt=%0d busy=%b want 48 1 3 0",
                             pass, xfers_b, done_b, fcnt_b, busy_b);
      end
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_first_frame();
    test_enable_drop();
    test_reset_mid();
    test_backpressure_frames();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
